// File: rtl/cic_pkg.sv
// Shared types and elaboration helpers for the CIC decimation filter.
package cic_pkg;

  typedef enum logic {
    MODE_INCR = 1'b0,
    MODE_REG  = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Bit growth of an ORDER-stage CIC at decimation 2^max_log2_m, plus the input bit.
  function automatic int acc_bits(input int order, input int max_log2_m);
    return order * max_log2_m + 1;
  endfunction

  function automatic int unsigned clamp_dec_log2(input int unsigned dec_log2,
                                                 input int unsigned max_log2_m);
    if (dec_log2 < 1) return 1;
    if (dec_log2 > max_log2_m) return max_log2_m;
    return dec_log2;
  endfunction

endpackage

// File: rtl/cic_integrator_chain.sv
// Rippling integrator cascade: every stage sees the freshly updated value of the
// stage before it on the same edge, and sum_next exposes the last stage's new value.
module cic_integrator_chain #(
  parameter int ORDER    = 2,
  parameter int ACC_BITS = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  input  logic                x,
  output logic [ACC_BITS-1:0] sum_next
);

  logic [ACC_BITS-1:0] integ_q [ORDER];
  logic [ACC_BITS-1:0] integ_d [ORDER];
  logic [ACC_BITS-1:0] ripple;

  // NOTE: every variable below is assigned on every path, so no latch is inferred.
  always_comb begin
    ripple = ACC_BITS'(x);
    for (int k = 0; k < ORDER; k++) begin
      ripple     = integ_q[k] + ripple;
      integ_d[k] = clr ? '0 : (en ? ripple : integ_q[k]);
    end
    sum_next = ripple;
  end

  // NOTE: <= makes every stage sample pre-edge values; the ripple lives in integ_d.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is a handful of registers, not a RAM, so it is reset element-wise.
      for (int k = 0; k < ORDER; k++) integ_q[k] <= '0;
    end else begin
      for (int k = 0; k < ORDER; k++) integ_q[k] <= integ_d[k];
    end
  end

endmodule

// File: rtl/cic_decimator.sv
// CIC decimator for a 1-bit modulator stream: incremental (one-shot) and regular
// (free-running) modes, runtime decimation ratio, valid/ready result with overrun.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int ORDER       = 2,
  parameter int MAX_LOG2_M  = 6,
  parameter int OUTPUT_BITS = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              x,
  input  logic                              x_valid,
  input  logic                              mode,
  input  logic [$clog2(MAX_LOG2_M+1)-1:0]   dec_log2,
  input  logic                              start,
  output logic                              busy,
  output logic [OUTPUT_BITS-1:0]            out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              overrun
);

  localparam int ACC_BITS = acc_bits(ORDER, MAX_LOG2_M);
  localparam int DEC_W    = $clog2(MAX_LOG2_M + 1);
  localparam int SETTLE_W = $clog2(ORDER + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(ORDER);

  if (ORDER < 1 || ORDER > 4) begin : g_bad_order
    $error("cic_decimator: ORDER must be within 1..4");
  end
  if (OUTPUT_BITS < ACC_BITS) begin : g_bad_width
    $error("cic_decimator: OUTPUT_BITS is narrower than ACC_BITS");
  end

  mode_e                  mode_cur;
  logic [DEC_W-1:0]       dec_eff;
  logic                   cfg_chg, accept, at_last, incr_last, reg_tick, integ_clr;
  logic                   incr_load, reg_load, load;
  logic [ACC_BITS-1:0]    sum_next, comb_acc, comb_out, load_val;
  logic [MAX_LOG2_M-1:0]  cnt_last;

  mode_e                  mode_q, mode_d;
  logic [DEC_W-1:0]       dec_q, dec_d;
  state_e                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic [MAX_LOG2_M-1:0]  cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic [ACC_BITS-1:0]    res_q, res_d;
  logic                   comb_stb_q, comb_stb_d;
  logic [ACC_BITS-1:0]    comb_in_q, comb_in_d;
  logic [ACC_BITS-1:0]    dly_q [ORDER];
  logic [ACC_BITS-1:0]    dly_d [ORDER];
  logic [SETTLE_W-1:0]    settle_q, settle_d;
  logic [OUTPUT_BITS-1:0] out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   overrun_q, overrun_d;

  assign mode_cur = mode_e'(mode);
  assign dec_eff  = DEC_W'(clamp_dec_log2(32'(dec_log2), MAX_LOG2_M));
  assign cnt_last = ~({MAX_LOG2_M{1'b1}} << dec_eff);

  cic_integrator_chain #(
    .ORDER   (ORDER),
    .ACC_BITS(ACC_BITS)
  ) u_integ (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (integ_clr),
    .en      (accept),
    .x       (x),
    .sum_next(sum_next)
  );

  // Sample acceptance, counter and decimation strobes.
  always_comb begin
    cfg_chg   = (mode_cur != mode_q) || (dec_eff != dec_q);
    accept    = x_valid && !cfg_chg &&
                ((mode_cur == MODE_REG) || (state_q == RUN && !start));
    at_last   = (cnt_q == cnt_last);
    incr_last = (mode_cur == MODE_INCR) && accept && at_last;
    reg_tick  = (mode_cur == MODE_REG) && accept && at_last;
    integ_clr = cfg_chg || ((mode_cur == MODE_INCR) && start);

    cnt_d = cnt_q;
    if (integ_clr)    cnt_d = '0;
    else if (accept)  cnt_d = at_last ? '0 : cnt_q + MAX_LOG2_M'(1);

    mode_d = mode_cur;
    dec_d  = dec_eff;
  end

  // Incremental FSM; a start while running restarts in place, discarding the old run.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!cfg_chg && mode_cur == MODE_INCR && start) state_d = RUN;
      RUN:     if (cfg_chg || incr_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d    = (state_q == RUN) && !cfg_chg;
    done_d    = incr_last;
    res_d     = incr_last ? sum_next : res_q;
    incr_load = done_q && !cfg_chg;
  end

  // Comb chain runs one edge behind the decimation tick on the registered sample.
  always_comb begin
    comb_stb_d = reg_tick;
    comb_in_d  = cfg_chg ? '0 : (reg_tick ? sum_next : comb_in_q);
    comb_acc   = comb_in_q;
    for (int k = 0; k < ORDER; k++) begin
      dly_d[k] = cfg_chg ? '0 : (comb_stb_q ? comb_acc : dly_q[k]);
      comb_acc = comb_acc - dly_q[k];
    end
    comb_out = comb_acc;

    settle_d = settle_q;
    if (cfg_chg)                                    settle_d = '0;
    else if (comb_stb_q && settle_q != SETTLE_DONE) settle_d = settle_q + SETTLE_W'(1);
    reg_load = comb_stb_q && !cfg_chg && (settle_q == SETTLE_DONE);
  end

  // Output register: a fresh result always wins over a same-edge handshake.
  always_comb begin
    load        = incr_load || reg_load;
    load_val    = incr_load ? res_q : comb_out;
    out_data_d  = load ? OUTPUT_BITS'(load_val) : out_data_q;
    out_valid_d = load || (out_valid_q && !out_ready);
    overrun_d   = cfg_chg ? 1'b0
                          : (overrun_q || (load && out_valid_q && !out_ready));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_INCR;
      dec_q       <= '0;
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      res_q       <= '0;
      comb_stb_q  <= 1'b0;
      comb_in_q   <= '0;
      for (int k = 0; k < ORDER; k++) dly_q[k] <= '0;
      settle_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      dec_q       <= dec_d;
      state_q     <= state_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      res_q       <= res_d;
      comb_stb_q  <= comb_stb_d;
      comb_in_q   <= comb_in_d;
      for (int k = 0; k < ORDER; k++) dly_q[k] <= dly_d[k];
      settle_q    <= settle_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign busy      = busy_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator (ORDER=2, MAX_LOG2_M=6, OUTPUT_BITS=16).
module tb_cic_decimator;

  logic        clk = 1'b0;
  logic        rst_n, x, x_valid, mode, start, out_ready;
  logic [2:0]  dec_log2;
  logic        busy, out_valid, overrun;
  logic [15:0] out_data;
  int          total = 0;
  int          bad   = 0;

  typedef struct {
    logic [2:0] dec;
    int         pat;       // 0 zeros, 1 ones, 2 alternating 1,0.., 3 single leading one
    bit         stall;     // x_valid low on every other cycle
    int         exp_data;
    int         exp_busy;
  } ivec_t;

  always #5 clk = ~clk;

  cic_decimator #(
    .ORDER      (2),
    .MAX_LOG2_M (6),
    .OUTPUT_BITS(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .x        (x),
    .x_valid  (x_valid),
    .mode     (mode),
    .dec_log2 (dec_log2),
    .start    (start),
    .busy     (busy),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun  (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic pat_bit(input int pat, input int i);
    case (pat)
      1:       return 1'b1;
      2:       return (i % 2 == 0);
      3:       return (i == 0);
      default: return 1'b0;
    endcase
  endfunction

  // One incremental conversion; samples are taken on negedges after each posedge.
  task automatic run_incr(input logic [2:0] dec, input int pat, input bit stall,
                          output int busy_cnt, output int nvalid, output logic [15:0] data);
    int idx;
    mode     = 1'b0;
    dec_log2 = dec;
    x_valid  = 1'b1;
    x        = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    busy_cnt = 0;
    nvalid   = 0;
    data     = '0;
    idx      = 0;
    for (int k = 0; k < 140; k++) begin
      if (busy) busy_cnt++;
      if (out_valid) begin
        nvalid++;
        data = out_data;
      end
      x_valid = stall ? (k % 2 == 0) : 1'b1;
      x       = pat_bit(pat, idx);
      if (x_valid) idx++;
      @(negedge clk);
    end
    x_valid = 1'b1;
  endtask

  // Regular mode with constant x=1; records the first two reported results.
  task automatic run_reg(input logic [2:0] dec, input int cycles,
                         output int k0, output int k1,
                         output logic [15:0] d0, output logic [15:0] d1, output int nv);
    mode      = 1'b1;
    dec_log2  = dec;
    x         = 1'b1;
    x_valid   = 1'b1;
    out_ready = 1'b1;
    k0 = -1; k1 = -1; d0 = '0; d1 = '0; nv = 0;
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      if (out_valid) begin
        nv++;
        if (k0 < 0) begin
          k0 = k;
          d0 = out_data;
        end else if (k1 < 0) begin
          k1 = k;
          d1 = out_data;
        end
      end
    end
  endtask

  initial begin
    ivec_t       vecs [8];
    int          bc, nv, nbusy, nvalid, nchg, first_k, k0, k1;
    logic [15:0] dat, d0, d1;

    vecs[0] = '{3'd4, 1, 1'b0, 136,  16};
    vecs[1] = '{3'd4, 2, 1'b0, 72,   16};
    vecs[2] = '{3'd0, 1, 1'b0, 3,    2};   // clamped up to M=2
    vecs[3] = '{3'd7, 1, 1'b0, 2080, 64};  // clamped down to M=64
    vecs[4] = '{3'd2, 0, 1'b0, 0,    4};
    vecs[5] = '{3'd3, 2, 1'b0, 20,   8};
    vecs[6] = '{3'd4, 3, 1'b0, 16,   16};
    vecs[7] = '{3'd2, 1, 1'b1, 10,   7};

    rst_n = 1'b0; x = 1'b0; x_valid = 1'b1; mode = 1'b0; start = 1'b0;
    out_ready = 1'b1; dec_log2 = 3'd4;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_valid", out_valid, 0);
    check("reset_data", out_data, 0);
    check("reset_overrun", overrun, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_incr(vecs[i].dec, vecs[i].pat, vecs[i].stall, bc, nv, dat);
      check($sformatf("vec%0d_data", i), dat, vecs[i].exp_data);
      check($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].exp_busy);
      check($sformatf("vec%0d_nvalid", i), nv, 1);
    end

    // Abort: restart on the ninth cycle of a run; only the restarted run reports.
    mode = 1'b0; dec_log2 = 3'd4; out_ready = 1'b1; x = 1'b1; x_valid = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; nbusy = 0; nvalid = 0; first_k = -1; dat = '0;
    for (int k = 0; k < 40; k++) begin
      if (busy) nbusy++;
      if (out_valid) begin
        nvalid++;
        dat = out_data;
        if (first_k < 0) first_k = k;
      end
      start = (k == 8);
      @(negedge clk);
    end
    start = 1'b0;
    check("abort_busy_cycles", nbusy, 25);
    check("abort_nvalid", nvalid, 1);
    check("abort_data", dat, 136);
    check("abort_first_valid_cycle", first_k, 26);

    // Backpressure across two results.
    out_ready = 1'b0;
    run_incr(3'd4, 1, 1'b0, bc, nv, dat);
    check("bp1_data", dat, 136);
    check("bp1_valid", out_valid, 1);
    check("bp1_overrun", overrun, 0);
    run_incr(3'd4, 2, 1'b0, bc, nv, dat);
    check("bp2_data", out_data, 72);
    check("bp2_valid", out_valid, 1);
    check("bp2_overrun", overrun, 1);

    // Mode toggle mid-run: state cleared, pending result kept, overrun cleared.
    x = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("toggle_pre_busy", busy, 1);
    mode = 1'b1;
    repeat (2) @(negedge clk);
    mode = 1'b0;
    repeat (2) @(negedge clk);
    check("toggle_busy", busy, 0);
    check("toggle_overrun", overrun, 0);
    check("toggle_valid_kept", out_valid, 1);
    check("toggle_data_kept", out_data, 72);
    nbusy = 0; nchg = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (out_data !== 16'd72 || out_valid !== 1'b1) nchg++;
    end
    check("toggle_later_busy", nbusy, 0);
    check("toggle_spurious_result", nchg, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("ready_clears_valid", out_valid, 0);

    // Asynchronous reset in the middle of a conversion.
    out_ready = 1'b0;
    run_incr(3'd4, 1, 1'b0, bc, nv, dat);
    check("rst_pre_valid", out_valid, 1);
    x = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_data", out_data, 0);
    check("rst_mid_overrun", overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Regular mode, M=16: two settling results suppressed, then 256 every 16 cycles.
    run_reg(3'd4, 90, k0, k1, d0, d1, nv);
    check("reg16_first_cycle", k0, 50);
    check("reg16_first_data", d0, 256);
    check("reg16_second_cycle", k1, 66);
    check("reg16_second_data", d1, 256);
    check("reg16_count", nv, 3);

    // Regular mode, M=64: 13-bit integrators wrap, comb output still 4096.
    run_reg(3'd6, 270, k0, k1, d0, d1, nv);
    check("reg64_first_cycle", k0, 194);
    check("reg64_first_data", d0, 4096);
    check("reg64_second_cycle", k1, 258);
    check("reg64_second_data", d1, 4096);
    check("reg64_count", nv, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
